// File: rtl/mips_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_pkg                                                               |
// | Opcode/funct encodings, FSM state and ALU operation types shared by    |
// | the bus-mastering MIPS core and its ALU.                               |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM   = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_cpu_bus_core_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_cpu_bus_core_if                                                   |
// | Avalon-style memory-mapped bus shared by fetch and data accesses.      |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
interface mips_cpu_bus_core_if;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    output address, write, read, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, write, read, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface
`default_nettype wire

// File: rtl/mips_alu.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_alu                                                               |
// | Combinational 32-bit ALU: add/sub, logic, shifts by shamt, slt/sltu.   |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module mips_alu
  import mips_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  output logic [31:0] y
);

  // Shifts operate on b (the rt operand), matching the MIPS R-type shift form.
  always_comb begin
    y = 32'h0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLT:  y = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {31'b0, (a < b)};
      ALU_SLL:  y = b << shamt;
      ALU_SRL:  y = b >> shamt;
      ALU_SRA:  y = $unsigned($signed(b) >>> shamt);
      ALU_LUI:  y = {b[15:0], 16'h0};
      default:  y = a + b;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_cpu_bus_core.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_cpu_bus_core                                                      |
// | Multicycle MIPS32 subset core with one memory-mapped master port.      |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module mips_cpu_bus_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       active,
  output logic [31:0]                register_v0,
  mips_cpu_bus_core_if.master        bus
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, npc_q, npc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] result_q, result_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_idx_q, wb_idx_d;
  logic        cur_jump_q, cur_jump_d;
  logic [31:0] cur_target_q, cur_target_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        active_q, active_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] address_q, address_d;
  logic [31:0] writedata_q, writedata_d;

  logic [31:0] gpr_q [32];
  logic        reg_we;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val, simm, zimm;

  alu_op_e     alu_op;
  logic [31:0] alu_b, alu_y;
  logic        dec_wb, dec_mem, dec_load, dec_jump, dec_link;
  logic [4:0]  dec_idx;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign shamt  = ir_q[10:6];
  assign funct  = ir_q[5:0];
  assign imm    = ir_q[15:0];
  assign simm   = sext16(imm);
  assign zimm   = {16'h0, imm};
  assign rs_val = gpr_q[rs];
  assign rt_val = gpr_q[rt];

  always_comb begin
    alu_op   = ALU_ADD;
    alu_b    = rt_val;
    dec_wb   = 1'b0;
    dec_idx  = rd;
    dec_mem  = 1'b0;
    dec_load = 1'b0;
    dec_jump = 1'b0;
    dec_link = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_wb = 1'b1;
        case (funct)
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_SRA:  alu_op = ALU_SRA;
          FN_JR: begin
            dec_wb   = 1'b0;
            dec_jump = 1'b1;
          end
          FN_JALR: begin
            dec_jump = 1'b1;
            dec_link = 1'b1;
          end
          default: dec_wb = 1'b0;
        endcase
      end
      OP_ADDIU: begin alu_b = simm; dec_wb = 1'b1; dec_idx = rt; end
      OP_SLTI:  begin alu_op = ALU_SLT;  alu_b = simm; dec_wb = 1'b1; dec_idx = rt; end
      OP_SLTIU: begin alu_op = ALU_SLTU; alu_b = simm; dec_wb = 1'b1; dec_idx = rt; end
      OP_ANDI:  begin alu_op = ALU_AND;  alu_b = zimm; dec_wb = 1'b1; dec_idx = rt; end
      OP_ORI:   begin alu_op = ALU_OR;   alu_b = zimm; dec_wb = 1'b1; dec_idx = rt; end
      OP_XORI:  begin alu_op = ALU_XOR;  alu_b = zimm; dec_wb = 1'b1; dec_idx = rt; end
      OP_LUI:   begin alu_op = ALU_LUI;  alu_b = zimm; dec_wb = 1'b1; dec_idx = rt; end
      OP_LW: begin
        alu_b    = simm;
        dec_wb   = 1'b1;
        dec_idx  = rt;
        dec_mem  = 1'b1;
        dec_load = 1'b1;
      end
      OP_SW: begin
        alu_b   = simm;
        dec_mem = 1'b1;
      end
      default: ;
    endcase
    // A jump sitting in another jump's delay slot has no effect at all.
    if (dec_jump && pend_q) begin
      dec_jump = 1'b0;
      dec_link = 1'b0;
      dec_wb   = 1'b0;
    end
  end

  mips_alu u_alu (
    .op    (alu_op),
    .a     (rs_val),
    .b     (alu_b),
    .shamt (shamt),
    .y     (alu_y)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    npc_d         = npc_q;
    ir_d          = ir_q;
    result_d      = result_q;
    wb_en_d       = wb_en_q;
    wb_idx_d      = wb_idx_q;
    cur_jump_d    = cur_jump_q;
    cur_target_d  = cur_target_q;
    pend_d        = pend_q;
    pend_target_d = pend_target_q;
    active_d      = active_q;
    read_d        = read_q;
    write_d       = write_q;
    address_d     = address_q;
    writedata_d   = writedata_q;

    case (state_q)
      ST_FETCH: begin
        if (!active_q) begin
          active_d  = 1'b1;
          read_d    = 1'b1;
          address_d = pc_q;
        end else if (!bus.waitrequest) begin
          ir_d    = bus.readdata;
          read_d  = 1'b0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        wb_en_d      = dec_wb;
        wb_idx_d     = dec_idx;
        cur_jump_d   = dec_jump;
        cur_target_d = rs_val;
        result_d     = dec_link ? (pc_q + 32'd8) : alu_y;
        if (dec_mem) begin
          state_d     = ST_MEM;
          read_d      = dec_load;
          write_d     = !dec_load;
          address_d   = {alu_y[31:2], 2'b00};
          writedata_d = rt_val;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (!bus.waitrequest) begin
          if (read_q) begin
            result_d = bus.readdata;
          end
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        if (pend_q) begin
          pc_d   = pend_target_q;
          pend_d = 1'b0;
        end else begin
          pc_d = npc_q;
        end
        npc_d = pc_d + 32'd4;
        if (cur_jump_q) begin
          pend_d        = 1'b1;
          pend_target_d = cur_target_q;
        end
        if (pend_q && (pend_target_q == 32'h0)) begin
          state_d  = ST_HALT;
          active_d = 1'b0;
        end else begin
          state_d   = ST_FETCH;
          read_d    = 1'b1;
          address_d = pc_d;
        end
      end
      ST_HALT: begin
        active_d = 1'b0;
        read_d   = 1'b0;
        write_d  = 1'b0;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_VECTOR;
      npc_q         <= RESET_VECTOR + 32'd4;
      ir_q          <= 32'h0;
      result_q      <= 32'h0;
      wb_en_q       <= 1'b0;
      wb_idx_q      <= 5'd0;
      cur_jump_q    <= 1'b0;
      cur_target_q  <= 32'h0;
      pend_q        <= 1'b0;
      pend_target_q <= 32'h0;
      active_q      <= 1'b0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      address_q     <= RESET_VECTOR;
      writedata_q   <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      npc_q         <= npc_d;
      ir_q          <= ir_d;
      result_q      <= result_d;
      wb_en_q       <= wb_en_d;
      wb_idx_q      <= wb_idx_d;
      cur_jump_q    <= cur_jump_d;
      cur_target_q  <= cur_target_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
      active_q      <= active_d;
      read_q        <= read_d;
      write_q       <= write_d;
      address_q     <= address_d;
      writedata_q   <= writedata_d;
    end
  end

  // r0 is never written, so it reads back as zero without a special case.
  assign reg_we = (state_q == ST_WB) && wb_en_q && (wb_idx_q != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        gpr_q[i] <= 32'h0;
      end
    end else if (reg_we) begin
      gpr_q[wb_idx_q] <= result_q;
    end
  end

  assign active         = active_q;
  assign register_v0    = gpr_q[2];
  assign bus.address    = address_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.writedata  = writedata_q;
  assign bus.byteenable = 4'b1111;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_bus_core.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mips_cpu_bus_core                                                   |
// | Directed programs against a stalling RAM model with a bus scoreboard.  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_mips_cpu_bus_core;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        active;
  logic [31:0] register_v0;

  mips_cpu_bus_core_if bus();

  mips_cpu_bus_core #(.RESET_VECTOR(RV)) dut (
    .clk         (clk),
    .reset       (reset),
    .active      (active),
    .register_v0 (register_v0),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  logic [31:0] mem [logic [31:0]];
  int          wcnt   = 0;
  int          wait_n = 0;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  assign bus.waitrequest = (bus.read || bus.write) && (wcnt < wait_n);

  always @(negedge clk) bus.readdata = rd_word(bus.address);

  always @(posedge clk) begin
    if (bus.read || bus.write) begin
      if (wcnt < wait_n) begin
        wcnt <= wcnt + 1;
      end else begin
        wcnt <= 0;
        if (bus.write) mem[bus.address] = bus.writedata;
      end
    end else begin
      wcnt <= 0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] v0_q[$];
  txn_t        t;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          halt_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic exp_f(input logic [31:0] a); exp_q.push_back('{1'b0, a, 32'h0}); endtask
  task automatic exp_r(input logic [31:0] a); exp_q.push_back('{1'b0, a, 32'h0}); endtask
  task automatic exp_w(input logic [31:0] a, input logic [31:0] d); exp_q.push_back('{1'b1, a, d}); endtask
  task automatic put(input int i, input logic [31:0] w); mem[RV + 32'(4 * i)] = w; endtask

  logic        prev_stall = 1'b0;
  logic        prev_active = 1'b0;
  logic        prev_rd, prev_wr;
  logic [31:0] prev_addr, prev_wdata;

  always @(negedge clk) begin
    if (reset) begin
      if (prev_stall) begin
        chk("stall_addr_stable", bus.address, prev_addr);
        chk("stall_rw_stable", {30'b0, bus.read, bus.write}, {30'b0, prev_rd, prev_wr});
        if (prev_wr) chk("stall_wdata_stable", bus.writedata, prev_wdata);
      end
      if ((bus.read || bus.write) && !bus.waitrequest) begin
        chk("rd_wr_exclusive", {31'b0, bus.read && bus.write}, 32'h0);
        chk("txn_byteenable", {28'b0, bus.byteenable}, 32'hF);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_txn: got addr %h wr %0b expected no transaction", bus.address, bus.write);
        end else begin
          t = exp_q.pop_front();
          chk("txn_kind_wr", {31'b0, bus.write}, {31'b0, t.wr});
          chk("txn_addr", bus.address, t.addr);
          if (t.wr) chk("txn_wdata", bus.writedata, t.data);
        end
      end
      if (prev_active && !active) begin
        halt_cnt++;
        chk("halt_bus_idle", {30'b0, bus.read, bus.write}, 32'h0);
        if (v0_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_halt: got v0 %h expected no halt", register_v0);
        end else begin
          chk("v0_at_halt", register_v0, v0_q.pop_front());
        end
      end
    end
    prev_stall  = reset && (bus.read || bus.write) && bus.waitrequest;
    prev_rd     = bus.read;
    prev_wr     = bus.write;
    prev_addr   = bus.address;
    prev_wdata  = bus.writedata;
    prev_active = reset && active;
  end

  // ---------------- stimulus helpers ----------------
  task automatic start(input int waits);
    reset = 1'b0;
    @(negedge clk);
    mem.delete();
    exp_q.delete();
    v0_q.delete();
    wait_n = waits;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_halt(input string name);
    int h0;
    int k;
    h0 = halt_cnt;
    k  = 0;
    while (halt_cnt == h0 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if (halt_cnt == h0) begin
      n_checks++;
      $display("FAIL %s_timeout: got no halt after %0d cycles expected halt", name, k);
    end
    repeat (6) @(negedge clk);
    chk({name, "_txns_left"}, 32'(exp_q.size()), 32'h0);
    chk({name, "_stays_halted"}, {31'b0, active}, 32'h0);
  endtask

  task automatic load_slt_prog(input logic [31:0] delay_insn);
    put(0, 32'h8C030004);   // lw   v1,4(zero)
    put(1, 32'h8C040008);   // lw   a0,8(zero)
    put(2, 32'h00000008);   // jr   zero
    put(3, delay_insn);
    mem[32'h4] = 32'h5;
    mem[32'h8] = 32'hFFFFFFFF;
    exp_f(RV); exp_r(32'h4); exp_f(RV + 4); exp_r(32'h8); exp_f(RV + 8); exp_f(RV + 12);
  endtask

  task automatic load_stld_prog();
    put(0, 32'h24031234);   // addiu v1,zero,0x1234
    put(1, 32'hAC030010);   // sw    v1,16(zero)
    put(2, 32'h8C020010);   // lw    v0,16(zero)
    put(3, 32'h00000008);   // jr    zero
    put(4, 32'h00000000);   // nop
  endtask

  task automatic exp_stld();
    exp_f(RV); exp_f(RV + 4); exp_w(32'h10, 32'h1234); exp_f(RV + 8);
    exp_r(32'h10); exp_f(RV + 12); exp_f(RV + 16);
    v0_q.push_back(32'h1234);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;

    // Reset state and first fetch, then SLTU program.
    start(0);
    @(negedge clk);
    chk("rst_active", {31'b0, active}, 32'h0);
    chk("rst_read", {31'b0, bus.read}, 32'h0);
    chk("rst_write", {31'b0, bus.write}, 32'h0);
    chk("rst_address", bus.address, RV);
    chk("rst_byteenable", {28'b0, bus.byteenable}, 32'hF);
    load_slt_prog(32'h0064102B);   // sltu v0,v1,a0
    v0_q.push_back(32'h1);
    release_reset();
    @(negedge clk);
    chk("boot_active", {31'b0, active}, 32'h1);
    chk("boot_read", {31'b0, bus.read}, 32'h1);
    chk("boot_write", {31'b0, bus.write}, 32'h0);
    chk("boot_address", bus.address, 32'hBFC00000);
    chk("boot_byteenable", {28'b0, bus.byteenable}, 32'hF);
    wait_halt("sltu");

    // Same program, signed compare: 5 < -1 is false.
    start(0);
    load_slt_prog(32'h0064102A);   // slt v0,v1,a0
    v0_q.push_back(32'h0);
    release_reset();
    wait_halt("slt");

    // Delay slot executes, halt without fetching address 0.
    start(0);
    put(0, 32'h00000008);          // jr    zero
    put(1, 32'h24020007);          // addiu v0,zero,7
    exp_f(RV); exp_f(RV + 4);
    v0_q.push_back(32'h7);
    release_reset();
    wait_halt("delay_slot");

    // SLTU program with 3 wait states per access.
    start(3);
    load_slt_prog(32'h0064102B);
    v0_q.push_back(32'h1);
    release_reset();
    wait_halt("sltu_wait3");

    // Store/load round trip.
    start(0);
    load_stld_prog();
    exp_stld();
    release_reset();
    wait_halt("store_load");

    // Shifts, logic immediates, LUI, SLTI/SLTIU, ADDU/SUBU, JALR link.
    start(1);
    put(0,  32'h2403FFF8);         // addiu v1,zero,-8
    put(1,  32'h00032043);         // sra   a0,v1,1
    put(2,  32'hAC040000);         // sw    a0,0(zero)
    put(3,  32'h00032F02);         // srl   a1,v1,28
    put(4,  32'h00053100);         // sll   a2,a1,4
    put(5,  32'h38C7FFFF);         // xori  a3,a2,0xffff
    put(6,  32'hAC070004);         // sw    a3,4(zero)
    put(7,  32'h3C088000);         // lui   t0,0x8000
    put(8,  32'h2C09FFFF);         // sltiu t1,zero,-1
    put(9,  32'h290A0001);         // slti  t2,t0,1
    put(10, 32'h012A5821);         // addu  t3,t1,t2
    put(11, 32'h01681023);         // subu  v0,t3,t0
    put(12, 32'h00008009);         // jalr  s0,zero
    put(13, 32'hAC100008);         // sw    s0,8(zero)
    exp_f(RV); exp_f(RV + 4); exp_f(RV + 8); exp_w(32'h0, 32'hFFFFFFFC);
    exp_f(RV + 12); exp_f(RV + 16); exp_f(RV + 20); exp_f(RV + 24); exp_w(32'h4, 32'h0000FF0F);
    exp_f(RV + 28); exp_f(RV + 32); exp_f(RV + 36); exp_f(RV + 40); exp_f(RV + 44);
    exp_f(RV + 48); exp_f(RV + 52); exp_w(32'h8, 32'hBFC00038);
    v0_q.push_back(32'h80000002);
    release_reset();
    wait_halt("alu_mix");

    // Asynchronous reset while a store is stalled, then a clean rerun.
    start(3);
    load_stld_prog();
    exp_f(RV); exp_f(RV + 4);
    release_reset();
    k = 0;
    while (!(bus.write && bus.waitrequest) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("mem_stall_reached", {31'b0, bus.write && bus.waitrequest}, 32'h1);
    chk("pre_reset_txns_left", 32'(exp_q.size()), 32'h0);
    #2 reset = 1'b0;
    #1;
    chk("async_active", {31'b0, active}, 32'h0);
    chk("async_read", {31'b0, bus.read}, 32'h0);
    chk("async_write", {31'b0, bus.write}, 32'h0);
    exp_q.delete();
    v0_q.delete();
    exp_stld();
    @(negedge clk);
    release_reset();
    @(negedge clk);
    chk("restart_active", {31'b0, active}, 32'h1);
    chk("restart_read", {31'b0, bus.read}, 32'h1);
    chk("restart_address", bus.address, 32'hBFC00000);
    wait_halt("after_async_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/mips_cpu_bus_core.md
Name: mips_cpu_bus_core

Overview:
- Multicycle MIPS32 subset CPU with a single Avalon-style memory-mapped master port, used for both instruction fetch and data access.
- Boots from a fixed reset vector and runs until it executes a jump to address 0. After the delay slot of that jump it halts and drops `active`.
- Exposes `$v0` (r2) for end-of-run checking.
- Sits between the testbench/top level and a word-addressed RAM model that stalls through `waitrequest`.

Parameters:
- RESET_VECTOR, 32'hBFC00000, address of the first instruction fetch.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. Low forces the reset state immediately.
- active  out  1  high while executing; low after halt or while in reset.
- register_v0  out  32  live copy of GPR r2.
- address  out  32  byte address, always word aligned (bits[1:0] = 0).
- write  out  1  write strobe.
- read  out  1  read strobe.
- waitrequest  in  1  slave stall; the current transaction is held while high.
- writedata  out  32  store data.
- byteenable  out  4  byte lanes; 4'b1111 for every word access.
- readdata  in  32  read data, valid in the cycle `waitrequest` is low with `read` high.

Behaviour:
- Reset (reset=0), asynchronous:
  - PC=RESET_VECTOR, next-PC=RESET_VECTOR+4, no pending jump.
  - All GPRs = 0.
  - State=FETCH, `active`=0, `read`=0, `write`=0, `byteenable`=4'b1111, `address`=RESET_VECTOR.
- First cycle after reset release:
  - `active`=1, `read`=1, `write`=0, `address`=32'hBFC00000, `byteenable`=4'b1111.
  - All of these are visible before the next rising edge.
- States: FETCH -> EXEC -> (MEM ->) WB -> FETCH. HALT is terminal.
- FETCH:
  - Drive read=1, address=PC.
  - Stay while waitrequest=1; bus outputs are held stable.
  - On waitrequest=0, latch readdata into IR and go to EXEC.
- EXEC:
  - Decode IR and read rs/rt.
  - Run the ALU. Sub-module is combinational; results and the MEM-state address are registered.
  - LW/SW compute rs + sign-extended imm16 and go to MEM. Everything else goes to WB.
- MEM:
  - LW drives read=1; SW drives write=1 with writedata=rt.
  - The address is the computed one.
  - Hold the transaction until waitrequest=0, then go to WB.
  - `read` and `write` are never high together.
- WB:
  - Write the result to rd (R-type) or rt (I-type). Writes to r0 are ignored.
  - PC update:
    - If a jump was pending from the previous instruction, PC <= target and the pending flag clears.
    - Otherwise PC <= PC+4.
  - If the current instruction is JR/JALR, record target=rs as pending. The delay-slot instruction executes next.
- Halt:
  - When the PC update in WB takes a pending target equal to 0, go to HALT instead of FETCH.
  - In HALT: `active`=0, `read`=0, `write`=0. register_v0 holds its value.
- Supported instructions; anything else is executed as a NOP:
  - R-type: ADDU, SUBU, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, JR, JALR.
  - I-type: ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LW, SW.
- Arithmetic and width rules:
  - All arithmetic is 32-bit modulo; no overflow traps.
  - SLTU and SLTIU compare unsigned. SLTIU still sign-extends its immediate before comparing.
  - SLT and SLTI compare signed.
  - ANDI, ORI and XORI zero-extend the immediate.
  - JALR writes PC+8 to rd.
- Back-to-back jumps: the jump sitting in a delay slot is treated as a NOP.

Decomposition:
- Package mips_pkg holds:
  - opcode and funct localparams;
  - the state enum (FETCH, EXEC, MEM, WB, HALT);
  - the ALU-op enum.
- One sub-module, mips_alu, implements add/sub/logic/shift/slt/sltu.
- The 32x32 register file stays inline in the core.

Test Plan:
- Reset and fetch: pulse reset low, then release.
  - Next negedge: active=1, address=32'hBFC00000, read=1, write=0, byteenable=4'b1111.
- SLTU unsigned compare: program at the vector is `lw v1,4(zero); lw a0,8(zero); jr zero; sltu v0,v1,a0`, with RAM[4]=5 and RAM[8]=32'hFFFFFFFF.
  - Ends with active=0 and register_v0=1.
  - The same program with `slt` in the delay slot gives v0=0.
- Delay slot plus halt: `jr zero` followed by `addiu v0,zero,7`.
  - v0=7 at halt.
  - The fetch address sequence is exactly BFC00000, BFC00004; there is no fetch from 0.
- Wait states: RAM holds waitrequest=1 for 3 cycles on every access.
  - address, read and byteenable stay stable throughout.
  - The final v0 is identical to the zero-wait run.
- Store/load round trip: `addiu v1,zero,0x1234; sw v1,16(zero); lw v0,16(zero); jr zero; nop`.
  - write=1 with address=16 and writedata=32'h1234.
  - v0=32'h1234 at halt.
- Async reset mid-run: assert reset low during a MEM stall.
  - active, read and write drop to 0 without waiting for a clock edge.
  - After release, fetch restarts at BFC00000.
